// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: word, fetch FSM state, IF/ID latch record
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t inst;
    word_t pc;
    word_t npc;
    logic  valid;
  } if_id_t;

  localparam word_t WORD_STEP = 32'd4;

  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/if_id_latch.sv
// rtl/if_id_latch.sv - IF/ID pipeline register with flush > stall > load > bubble priority
module if_id_latch
  import cpu_types_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   flush_i,
  input  logic   stall_i,
  input  logic   load_i,
  input  if_id_t data_i,
  output if_id_t data_o
);

  if_id_t latch_q, latch_d;

  // A bubble clears every field so a squashed slot never leaks a stale PC downstream.
  always_comb begin
    latch_d = latch_q;
    if (flush_i) begin
      latch_d = '0;
    end else if (stall_i) begin
      latch_d = latch_q;
    end else if (load_i) begin
      latch_d = data_i;
    end else begin
      latch_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      latch_q <= '0;
    end else begin
      latch_q <= latch_d;
    end
  end

  assign data_o = latch_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC register, fetch FSM and IF/ID latch
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t imemload,
  input  logic  stall,
  input  logic  flush,
  input  logic  pc_load,
  input  word_t pc_target,
  input  logic  halt_dec,
  output logic  iREN,
  output word_t imemaddr,
  output word_t inst_o,
  output word_t pc_o,
  output word_t npc_o,
  output logic  valid_o
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d, pc_plus4;
  logic         in_fetch, in_halted;
  logic         latch_load, latch_stall;
  if_id_t       latch_in, latch_out;

  assign in_fetch  = (state_q == FETCH);
  assign in_halted = (state_q == HALTED);
  assign pc_plus4  = pc_q + WORD_STEP;

  always_comb begin
    state_d = state_q;
    iREN    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        iREN = 1'b1;
        if (halt_dec && !flush) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A redirect wins even without ihit or under stall; only HALTED freezes the PC.
  always_comb begin
    pc_d = pc_q;
    if (pc_load && !in_halted) begin
      pc_d = word_align(pc_target);
    end else if (in_fetch && ihit && !stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A fetch landing alongside a redirect is wrong-path and is dropped.
  assign latch_load  = in_fetch && ihit && !pc_load;
  assign latch_stall = stall && !in_halted;

  always_comb begin
    latch_in.inst  = imemload;
    latch_in.pc    = pc_q;
    latch_in.npc   = pc_plus4;
    latch_in.valid = 1'b1;
  end

  if_id_latch u_if_id (
    .clk_i   (CLK),
    .rst_i   (RST),
    .flush_i (flush),
    .stall_i (latch_stall),
    .load_i  (latch_load),
    .data_i  (latch_in),
    .data_o  (latch_out)
  );

  assign imemaddr = pc_q;
  assign inst_o   = latch_out.inst;
  assign pc_o     = latch_out.pc;
  assign npc_o    = latch_out.npc;
  assign valid_o  = latch_out.valid;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL take parameter PC_INIT, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port CLK  input  1  the single system clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port RST  input  1  a synchronous, active-high reset.
REQ-004 The block SHALL have port ihit  input  1  meaning the instruction memory returned imemload this cycle.
REQ-005 The block SHALL have port imemload  input  32  meaning the fetched instruction word.
REQ-006 The block SHALL have port stall  input  1  meaning hold the IF/ID latch and the PC (hazard unit).
REQ-007 The block SHALL have port flush  input  1  meaning squash the IF/ID latch contents.
REQ-008 The block SHALL have port pc_load  input  1  meaning a redirect is valid this cycle (jump, JR or taken branch).
REQ-009 The block SHALL have port pc_target  input  32  meaning the redirect address.
REQ-010 The block SHALL have port halt_dec  input  1  meaning the decoder flagged HALT on the latched instruction.
REQ-011 The block SHALL have port iREN  output  1  meaning instruction read enable.
REQ-012 The block SHALL have port imemaddr  output  32  meaning the fetch address, equal to the current PC.
REQ-013 The block SHALL have port inst_o  output  32  meaning the latched instruction fed to decode.
REQ-014 The block SHALL have port pc_o  output  32  meaning the PC of inst_o.
REQ-015 The block SHALL have port npc_o  output  32  meaning pc_o+4, used for JAL link and branch base.
REQ-016 The block SHALL have port valid_o  output  1  meaning inst_o is a real instruction; 0 means bubble.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, FETCH and HALTED; the reset state is IDLE, IDLE goes to FETCH unconditionally after one cycle, and iREN SHALL be 1 only in FETCH.
REQ-018 In FETCH, halt_dec=1 with flush=0 SHALL move the FSM to HALTED; HALTED SHALL be left only by RST.
REQ-019 imemaddr SHALL equal the PC combinationally; there is zero added address latency.
REQ-020 PC update priority SHALL be: pc_load, which sets PC to {pc_target[31:2],2'b00} in any state except HALTED, even when stall or ihit is 0; then ihit&!stall in FETCH, which sets PC to PC+4; otherwise PC holds.
REQ-021 PC+4 SHALL use 32-bit modulo arithmetic, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-022 IF/ID latch priority SHALL be: flush clears the latch (inst_o=0, valid_o=0, pc_o and npc_o=0); then stall holds all latch fields; then ihit&!pc_load in FETCH loads inst_o=imemload, pc_o=PC, npc_o=PC+4, valid_o=1; otherwise the latch takes a bubble (valid_o=0, inst_o=0).
REQ-023 A fetch completing in the same cycle as pc_load SHALL be discarded, because it is on the wrong path.
REQ-024 In HALTED, the latch SHALL only take bubbles or flushes, and the PC SHALL be frozen.
REQ-025 flush and stall asserted together SHALL flush.

Reset
REQ-026 RST SHALL dominate every other input; on the next edge PC=PC_INIT, FSM=IDLE, inst_o=0, pc_o=0, npc_o=0 and valid_o=0, and iREN=0 during IDLE.
REQ-027 RST asserted mid-fetch SHALL abandon the request; any ihit arriving in that cycle SHALL be ignored.

Structure
REQ-028 The fetch FSM state enum and the IF/ID latch struct (inst, pc, npc, valid) SHALL live in cpu_types_pkg alongside word_t.
REQ-029 The IF/ID latch SHALL be a sub-module, if_id_latch, with flush/stall/load controls; the PC register and FSM SHALL stay in fetch_stage.

Verification
REQ-030 The bench SHALL check: reset with PC_INIT=0, then ihit=1 every cycle for 3 cycles -> imemaddr 0,4,8; pc_o 0,4; valid_o=1 from the 2nd fetch edge.
REQ-031 The bench SHALL check: ihit=0 for 3 cycles with imemaddr=0x10 -> PC holds at 0x10, valid_o=0; then ihit=1 -> inst_o=imemload, pc_o=0x10, npc_o=0x14.
REQ-032 The bench SHALL check: pc_load=1, pc_target=0x0000_0203 with ihit=1 and stall=1 -> next PC=0x200, latch held.
REQ-033 The bench SHALL check: flush=1 with stall=1 and ihit=1 -> valid_o=0, inst_o=0.
REQ-034 The bench SHALL check: halt_dec=1 -> next cycle iREN=0 and the PC is frozen for 10 cycles; then RST -> PC=PC_INIT, state IDLE.
REQ-035 The bench SHALL check: PC=0xFFFF_FFFC with ihit=1 -> next PC=0x0, npc_o=0x0.
